// File: rtl/warp_launcher.sv
// ----------------------------------------------------------------------------
// warp_launcher
//
// Block-level warp launcher for one SIMT core. It accepts a thread-block
// launch (start PC, thread count) and writes the initial context of each warp
// into the warp-context store, one warp per cycle. The last warp gets a
// partial active mask when the thread count is not a multiple of WARP_SIZE.
// It then waits for every warp it launched to report done, pulses block_done,
// and re-arms for the next launch.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   launch_valid/ready    launch handshake (ready only while idle)
//   launch_pc             start PC shared by all warps of the block
//   launch_thread_count   threads in the block (1 .. NUM_WARPS*WARP_SIZE)
//   abort                 synchronous abandon of the current block
//   init_valid/warp_id/pc/mask   one warp-context write per cycle
//   warp_done             per-slot done flags from the context store
//   launched_mask         slots owned by the current block
//   busy                  launcher is not idle
//   block_done            one-cycle pulse when all launched warps are done
//   launch_error          one-cycle pulse when a request is rejected
// ----------------------------------------------------------------------------
package warp_launcher_pkg;
    localparam int WARP_SIZE  = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_e;
endpackage

module warp_launcher
    import warp_launcher_pkg::*;
#(
    parameter int NUM_WARPS     = 4,
    parameter int WARP_SIZE     = warp_launcher_pkg::WARP_SIZE,
    parameter int DATA_WIDTH    = warp_launcher_pkg::DATA_WIDTH,
    parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS),
    parameter int CNT_WIDTH     = $clog2(NUM_WARPS * WARP_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     launch_valid,
    output logic                     launch_ready,
    input  logic [DATA_WIDTH-1:0]    launch_pc,
    input  logic [CNT_WIDTH-1:0]     launch_thread_count,
    input  logic                     abort,
    output logic                     init_valid,
    output logic [WARP_ID_WIDTH-1:0] init_warp_id,
    output logic [DATA_WIDTH-1:0]    init_pc,
    output logic [WARP_SIZE-1:0]     init_mask,
    input  logic [NUM_WARPS-1:0]     warp_done,
    output logic [NUM_WARPS-1:0]     launched_mask,
    output logic                     busy,
    output logic                     block_done,
    output logic                     launch_error
);

    // WARP_SIZE is a power of two, so the remainder is a bit slice and the
    // division is a shift.
    localparam int WS_BITS = $clog2(WARP_SIZE);
    localparam int SUM_W   = CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] MAX_THREADS = CNT_WIDTH'(NUM_WARPS * WARP_SIZE);

    state_e                   state_q, state_d;
    logic                     init_valid_q, init_valid_d;
    logic [WARP_ID_WIDTH-1:0] init_warp_id_q, init_warp_id_d;
    logic [DATA_WIDTH-1:0]    init_pc_q, init_pc_d;
    logic [WARP_SIZE-1:0]     init_mask_q, init_mask_d;
    logic [NUM_WARPS-1:0]     launched_mask_q, launched_mask_d;
    logic                     block_done_q, block_done_d;
    logic                     launch_error_q, launch_error_d;
    logic [WARP_ID_WIDTH-1:0] last_warp_q, last_warp_d;
    logic [WS_BITS-1:0]       rem_q, rem_d;

    logic                     count_bad;
    logic [WARP_ID_WIDTH-1:0] req_last_warp;
    logic [WS_BITS-1:0]       req_rem;

    // Active mask for one warp: full, unless it is the last warp of a block
    // whose thread count leaves a remainder.
    function automatic logic [WARP_SIZE-1:0] warp_mask(input logic             is_last,
                                                       input logic [WS_BITS-1:0] rem);
        if (is_last && rem != '0) begin
            return (WARP_SIZE'(1) << rem) - WARP_SIZE'(1);
        end
        return '1;
    endfunction

    assign count_bad = (launch_thread_count == '0) || (launch_thread_count > MAX_THREADS);
    assign req_rem   = launch_thread_count[WS_BITS-1:0];
    // ceil(count / WARP_SIZE) - 1, summed one bit wider so count + WARP_SIZE-1
    // cannot overflow. Only meaningful when count_bad is low.
    assign req_last_warp = WARP_ID_WIDTH'(
        (({1'b0, launch_thread_count} + SUM_W'(WARP_SIZE - 1)) >> WS_BITS) - SUM_W'(1));

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d         = state_q;
        init_valid_d    = 1'b0;
        init_warp_id_d  = init_warp_id_q;
        init_pc_d       = init_pc_q;
        init_mask_d     = init_mask_q;
        launched_mask_d = launched_mask_q;
        block_done_d    = 1'b0;
        launch_error_d  = 1'b0;
        last_warp_d     = last_warp_q;
        rem_d           = rem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (launch_valid) begin
                    if (count_bad) begin
                        launch_error_d = 1'b1;
                    end else begin
                        // The warp-0 write is registered on the acceptance
                        // edge so it appears in the very next cycle.
                        state_d         = ST_LAUNCH;
                        last_warp_d     = req_last_warp;
                        rem_d           = req_rem;
                        init_valid_d    = 1'b1;
                        init_warp_id_d  = '0;
                        init_pc_d       = launch_pc;
                        init_mask_d     = warp_mask(req_last_warp == '0, req_rem);
                        launched_mask_d = NUM_WARPS'(1);
                    end
                end
            end
            ST_LAUNCH: begin
                // init_warp_id_q is the warp being written this cycle.
                if (init_warp_id_q == last_warp_q) begin
                    state_d = ST_WAIT;
                end else begin
                    init_valid_d    = 1'b1;
                    init_warp_id_d  = init_warp_id_q + WARP_ID_WIDTH'(1);
                    init_mask_d     = warp_mask(init_warp_id_d == last_warp_q, rem_q);
                    launched_mask_d = launched_mask_q | (NUM_WARPS'(1) << init_warp_id_d);
                end
            end
            ST_WAIT: begin
                if ((warp_done & launched_mask_q) == launched_mask_q) begin
                    state_d      = ST_DONE;
                    block_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d         = ST_IDLE;
                launched_mask_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything above, but only once a block is active.
        if (abort && state_q != ST_IDLE) begin
            state_d         = ST_IDLE;
            init_valid_d    = 1'b0;
            launched_mask_d = '0;
            block_done_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            init_valid_q    <= 1'b0;
            init_warp_id_q  <= '0;
            init_pc_q       <= '0;
            init_mask_q     <= '0;
            launched_mask_q <= '0;
            block_done_q    <= 1'b0;
            launch_error_q  <= 1'b0;
            last_warp_q     <= '0;
            rem_q           <= '0;
        end else begin
            state_q         <= state_d;
            init_valid_q    <= init_valid_d;
            init_warp_id_q  <= init_warp_id_d;
            init_pc_q       <= init_pc_d;
            init_mask_q     <= init_mask_d;
            launched_mask_q <= launched_mask_d;
            block_done_q    <= block_done_d;
            launch_error_q  <= launch_error_d;
            last_warp_q     <= last_warp_d;
            rem_q           <= rem_d;
        end
    end

    assign launch_ready  = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign init_valid    = init_valid_q;
    assign init_warp_id  = init_warp_id_q;
    assign init_pc       = init_pc_q;
    assign init_mask     = init_mask_q;
    assign launched_mask = launched_mask_q;
    assign block_done    = block_done_q;
    assign launch_error  = launch_error_q;

endmodule

// File: tb/tb_warp_launcher.sv
// ----------------------------------------------------------------------------
// tb_warp_launcher
//
// Self-checking bench for warp_launcher with NUM_WARPS = 4, WARP_SIZE = 32.
// A table of launch requests with hand-computed init writes is applied in a
// loop, followed by hand-written sequences for completion ordering, a request
// held across a busy block, abort, and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_warp_launcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        launch_valid;
    logic        launch_ready;
    logic [31:0] launch_pc;
    logic [7:0]  launch_thread_count;
    logic        abort;
    logic        init_valid;
    logic [1:0]  init_warp_id;
    logic [31:0] init_pc;
    logic [31:0] init_mask;
    logic [3:0]  warp_done;
    logic [3:0]  launched_mask;
    logic        busy;
    logic        block_done;
    logic        launch_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]        count;
        logic [31:0]       pc;
        int                n_writes;
        logic [3:0][31:0]  masks;    // masks[w] is the expected mask of warp w
        logic [3:0]        exp_lm;
        logic              exp_err;
    } vec_t;

    vec_t vecs[6];

    warp_launcher #(.NUM_WARPS(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .launch_valid        (launch_valid),
        .launch_ready        (launch_ready),
        .launch_pc           (launch_pc),
        .launch_thread_count (launch_thread_count),
        .abort               (abort),
        .init_valid          (init_valid),
        .init_warp_id        (init_warp_id),
        .init_pc             (init_pc),
        .init_mask           (init_mask),
        .warp_done           (warp_done),
        .launched_mask       (launched_mask),
        .busy                (busy),
        .block_done          (block_done),
        .launch_error        (launch_error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " launch_ready"},  launch_ready,  1);
        check({tag, " busy"},          busy,          0);
        check({tag, " init_valid"},    init_valid,    0);
        check({tag, " init_warp_id"},  init_warp_id,  0);
        check({tag, " init_pc"},       init_pc,       0);
        check({tag, " init_mask"},     init_mask,     0);
        check({tag, " launched_mask"}, launched_mask, 0);
        check({tag, " block_done"},    block_done,    0);
        check({tag, " launch_error"},  launch_error,  0);
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        string tag;
        tag = $sformatf("vec%0d", idx);
        launch_valid        = 1'b1;
        launch_thread_count = t.count;
        launch_pc           = t.pc;
        tick();                          // acceptance edge
        launch_valid        = 1'b0;
        if (t.exp_err) begin
            check({tag, " err_pulse"},   launch_error, 1);
            check({tag, " err_no_init"}, init_valid,   0);
            check({tag, " err_ready"},   launch_ready, 1);
            tick();
            check({tag, " err_clear"},    launch_error, 0);
            check({tag, " err_no_init2"}, init_valid,   0);
            check({tag, " err_ready2"},   launch_ready, 1);
        end else begin
            for (int w = 0; w < t.n_writes; w++) begin
                if (w > 0) tick();
                check($sformatf("%s w%0d init_valid", tag, w), init_valid,   1);
                check($sformatf("%s w%0d warp_id", tag, w),    init_warp_id, 32'(w));
                check($sformatf("%s w%0d pc", tag, w),         init_pc,      t.pc);
                check($sformatf("%s w%0d mask", tag, w),       init_mask,    t.masks[w]);
                check($sformatf("%s w%0d busy", tag, w),       busy,         1);
                check($sformatf("%s w%0d no_err", tag, w),     launch_error, 0);
            end
            tick();                      // first WAIT cycle
            check({tag, " wait init_valid"}, init_valid,    0);
            check({tag, " wait lm"},         launched_mask, t.exp_lm);
            check({tag, " wait busy"},       busy,          1);
            check({tag, " wait ready"},      launch_ready,  0);
            warp_done = 4'b1111;         // includes slots outside the block
            tick();
            check({tag, " block_done"}, block_done, 1);
            warp_done = 4'b0000;
            tick();
            check({tag, " block_done_end"}, block_done,    0);
            check({tag, " rearm ready"},    launch_ready,  1);
            check({tag, " rearm lm"},       launched_mask, 0);
        end
    endtask

    initial begin
        vecs[0] = '{8'd70,  32'h0000_1000, 3,
                    {32'h0, 32'h0000_003F, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'b0111, 1'b0};
        vecs[1] = '{8'd128, 32'h0000_2000, 4,
                    {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'b1111, 1'b0};
        vecs[2] = '{8'd32,  32'h0000_3000, 1,
                    {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF}, 4'b0001, 1'b0};
        vecs[3] = '{8'd1,   32'hDEAD_BEE0, 1,
                    {32'h0, 32'h0, 32'h0, 32'h0000_0001}, 4'b0001, 1'b0};
        vecs[4] = '{8'd0,   32'h0000_4000, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 1'b1};
        vecs[5] = '{8'd129, 32'h0000_5000, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 1'b1};

        rst_n               = 1'b0;
        launch_valid        = 1'b0;
        launch_pc           = '0;
        launch_thread_count = '0;
        abort               = 1'b0;
        warp_done           = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset ready", launch_ready, 1);

        for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

        // Completion ordering: flags 3, then 2, 0, 1, accumulated.
        launch_valid = 1'b1; launch_thread_count = 8'd70; launch_pc = 32'h0000_1000;
        tick();
        launch_valid = 1'b0;
        tick(); tick(); tick();          // writes 1, 2, then first WAIT cycle
        check("order wait lm", launched_mask, 4'b0111);
        warp_done = 4'b1000; tick();
        check("order bit3 no done", block_done, 0);
        warp_done = 4'b1100; tick();
        check("order bit2 no done", block_done, 0);
        warp_done = 4'b1101; tick();
        check("order bit0 no done", block_done, 0);
        check("order bit0 busy", busy, 1);
        warp_done = 4'b1111; tick();
        check("order bit1 done", block_done, 1);
        check("order done not ready", launch_ready, 0);
        tick();
        check("order pulse single", block_done, 0);
        check("order ready", launch_ready, 1);
        warp_done = 4'b0000;

        // Held request: a second request waits out the first block. Abort is
        // asserted together with the first request in IDLE and must not matter.
        launch_valid = 1'b1; launch_thread_count = 8'd32; launch_pc = 32'h0000_1000;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("held first init_valid", init_valid, 1);
        check("held first pc", init_pc, 32'h0000_1000);
        launch_thread_count = 8'd64; launch_pc = 32'h0000_2000;
        tick();
        check("held wait no init", init_valid, 0);
        check("held wait not ready", launch_ready, 0);
        tick();
        check("held wait2 no init", init_valid, 0);
        warp_done = 4'b0001; tick();
        check("held block_done", block_done, 1);
        check("held done no init", init_valid, 0);
        warp_done = 4'b0000; tick();
        check("held idle ready", launch_ready, 1);
        check("held idle no init", init_valid, 0);
        tick();                          // second acceptance edge
        launch_valid = 1'b0;
        check("held2 w0 valid", init_valid, 1);
        check("held2 w0 pc", init_pc, 32'h0000_2000);
        check("held2 w0 id", init_warp_id, 0);
        tick();
        check("held2 w1 id", init_warp_id, 1);
        check("held2 w1 mask", init_mask, 32'hFFFF_FFFF);
        tick();
        check("held2 wait no init", init_valid, 0);
        check("held2 lm", launched_mask, 4'b0011);
        abort = 1'b1; tick();            // abort from WAIT
        abort = 1'b0;
        check("held2 abort idle", launch_ready, 1);
        check("held2 abort lm", launched_mask, 0);
        check("held2 abort no done", block_done, 0);

        // Abort during LAUNCH after the first of three writes.
        launch_valid = 1'b1; launch_thread_count = 8'd70; launch_pc = 32'h0000_1000;
        tick();
        launch_valid = 1'b0;
        check("abort w0 valid", init_valid, 1);
        abort = 1'b1; tick();
        abort = 1'b0;
        check("abort init_valid", init_valid,    0);
        check("abort lm",         launched_mask, 0);
        check("abort ready",      launch_ready,  1);
        check("abort busy",       busy,          0);
        check("abort no done",    block_done,    0);
        warp_done = 4'b1111; tick();
        check("abort later no done", block_done, 0);
        check("abort later no init", init_valid, 0);
        warp_done = 4'b0000;

        // Asynchronous reset while in WAIT.
        launch_valid = 1'b1; launch_thread_count = 8'd70; launch_pc = 32'h0000_1000;
        tick();
        launch_valid = 1'b0;
        tick(); tick(); tick();
        check("rst pre busy", busy, 1);
        rst_n = 1'b0;
        #2;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst post ready", launch_ready, 1);
        check("rst post no init", init_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
